toy_conv_tile_sched: RTL and testbench

Tile scheduler for the toy conv1 layer mapped as a Toeplitz GEMM: an M×K activation matrix times a K×COUT weight matrix. It breaks the output into ARR×ARR tiles for an output-stationary ARR×ARR systolic array. For each tile it clears the array accumulators, streams K activation and weight words from the tile-packed SRAM buffers, waits out the array skew, then drains valid output rows to the writeback path under ready/valid backpressure. It sits between the host start/done interface and the array, its buffers and its writeback.

---
 rtl/toy_conv_tile_sched.sv | 218 +++++++++++++++++++++
 tb/tb_toy_conv_tile_sched.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/toy_conv_tile_sched.sv
// Tile scheduler for an output-stationary ARR x ARR systolic array computing an M x K by K x COUT GEMM.
// Latency: per tile 1 (clear) + K (feed) + 2*ARR-1 (flush) + valid rows + 1 (next); done one cycle after the last tile.
// Backpressure: rows are offered on wb_valid and advance only on wb_valid && wb_ready; outputs hold while wb_ready is low.
//
// Ports:
//   clk, n_rst          clock (rising edge), asynchronous active-low reset
//   start, abort        layer start (IDLE only), synchronous abort to IDLE (wins over everything)
//   busy, done          not-IDLE indicator, one-cycle completion pulse
//   acc_clr, mac_en     array accumulator clear, array shift/MAC enable
//   a_rd_en, a_addr     activation buffer read, address mt*K + k
//   w_rd_en, w_addr     weight buffer read, address ct*K + k
//   wb_valid/wb_ready   writeback handshake for row wb_row (global row wb_m) of column tile wb_ct
module toy_conv_tile_sched #(
  parameter int M      = 25,
  parameter int K      = 9,
  parameter int COUT   = 4,
  parameter int ARR    = 4,
  parameter int ADDR_W = 8,
  localparam int MT    = (M + ARR - 1) / ARR,
  localparam int CT    = (COUT + ARR - 1) / ARR,
  localparam int SKEW  = 2 * ARR - 1,
  localparam int ROW_W = (ARR > 1) ? $clog2(ARR) : 1,
  localparam int M_W   = (M > 1) ? $clog2(M) : 1,
  localparam int CT_W  = (CT > 1) ? $clog2(CT) : 1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              acc_clr,
  output logic              mac_en,
  output logic              a_rd_en,
  output logic [ADDR_W-1:0] a_addr,
  output logic              w_rd_en,
  output logic [ADDR_W-1:0] w_addr,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [ROW_W-1:0]  wb_row,
  output logic [M_W-1:0]    wb_m,
  output logic [CT_W-1:0]   wb_ct
);

  localparam int MT_W = (MT > 1) ? $clog2(MT) : 1;
  localparam int K_W  = (K > 1) ? $clog2(K) : 1;
  localparam int S_W  = (SKEW > 1) ? $clog2(SKEW) : 1;

  localparam logic [MT_W-1:0]  MT_LAST = MT_W'(MT - 1);
  localparam logic [CT_W-1:0]  CT_LAST = CT_W'(CT - 1);
  localparam logic [K_W-1:0]   K_LAST  = K_W'(K - 1);
  localparam logic [S_W-1:0]   S_LAST  = S_W'(SKEW - 1);
  localparam logic [ROW_W-1:0] R_LAST  = ROW_W'(ARR - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLR   = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_NEXT  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  // Buffer addresses must fit the address width without wrapping.
  if (MT * K > 2 ** ADDR_W || CT * K > 2 ** ADDR_W) begin : g_addr_range_bad
    $error("toy_conv_tile_sched: MT*K or CT*K exceeds 2**ADDR_W");
  end

  logic [2:0]       state_q, state_d;
  logic [MT_W-1:0]  mt_q, mt_d;
  logic [CT_W-1:0]  ct_q, ct_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [S_W-1:0]   f_q, f_d;
  logic [ROW_W-1:0] r_q, r_d;
  logic             row_last;

  // Last row of a tile: either the array edge or the final row of the matrix.
  assign row_last = (r_q == R_LAST) || (int'(mt_q) * ARR + int'(r_q) + 1 >= M);

  always_comb begin
    state_d = state_q;
    mt_d    = mt_q;
    ct_d    = ct_q;
    k_d     = k_q;
    f_d     = f_q;
    r_d     = r_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLR;
          mt_d    = '0;
          ct_d    = '0;
        end
      end
      S_CLR: begin
        state_d = S_FEED;
        k_d     = '0;
      end
      S_FEED: begin
        if (k_q == K_LAST) begin
          state_d = S_FLUSH;
          f_d     = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_FLUSH: begin
        if (f_q == S_LAST) begin
          state_d = S_DRAIN;
          r_d     = '0;
        end else begin
          f_d = f_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (wb_ready) begin
          if (row_last) state_d = S_NEXT;
          else          r_d     = r_q + 1'b1;
        end
      end
      S_NEXT: begin
        if (ct_q != CT_LAST) begin
          ct_d    = ct_q + 1'b1;
          state_d = S_CLR;
        end else if (mt_q != MT_LAST) begin
          ct_d    = '0;
          mt_d    = mt_q + 1'b1;
          state_d = S_CLR;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      mt_d    = '0;
      ct_d    = '0;
      k_d     = '0;
      f_d     = '0;
      r_d     = '0;
    end
  end

  // Outputs are decoded from the next state and registered, so each output
  // reflects the state/counters of the cycle in which it is visible.
  logic              busy_d, done_d, acc_clr_d, mac_en_d, rd_en_d, wb_valid_d;
  logic [ADDR_W-1:0] a_addr_d, w_addr_d;
  logic [ROW_W-1:0]  wb_row_d;
  logic [M_W-1:0]    wb_m_d;
  logic [CT_W-1:0]   wb_ct_d;

  always_comb begin
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    acc_clr_d  = (state_d == S_CLR);
    mac_en_d   = (state_d == S_FEED) || (state_d == S_FLUSH);
    rd_en_d    = (state_d == S_FEED);
    wb_valid_d = (state_d == S_DRAIN);
    a_addr_d   = '0;
    w_addr_d   = '0;
    wb_row_d   = '0;
    wb_m_d     = '0;
    wb_ct_d    = '0;
    if (rd_en_d) begin
      a_addr_d = ADDR_W'(int'(mt_d) * K + int'(k_d));
      w_addr_d = ADDR_W'(int'(ct_d) * K + int'(k_d));
    end
    if (wb_valid_d) begin
      wb_row_d = r_d;
      wb_m_d   = M_W'(int'(mt_d) * ARR + int'(r_d));
      wb_ct_d  = ct_d;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= S_IDLE;
      mt_q     <= '0;
      ct_q     <= '0;
      k_q      <= '0;
      f_q      <= '0;
      r_q      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      acc_clr  <= 1'b0;
      mac_en   <= 1'b0;
      a_rd_en  <= 1'b0;
      w_rd_en  <= 1'b0;
      a_addr   <= '0;
      w_addr   <= '0;
      wb_valid <= 1'b0;
      wb_row   <= '0;
      wb_m     <= '0;
      wb_ct    <= '0;
    end else begin
      state_q  <= state_d;
      mt_q     <= mt_d;
      ct_q     <= ct_d;
      k_q      <= k_d;
      f_q      <= f_d;
      r_q      <= r_d;
      busy     <= busy_d;
      done     <= done_d;
      acc_clr  <= acc_clr_d;
      mac_en   <= mac_en_d;
      a_rd_en  <= rd_en_d;
      w_rd_en  <= rd_en_d;
      a_addr   <= a_addr_d;
      w_addr   <= w_addr_d;
      wb_valid <= wb_valid_d;
      wb_row   <= wb_row_d;
      wb_m     <= wb_m_d;
      wb_ct    <= wb_ct_d;
    end
  end

endmodule

// File: tb/tb_toy_conv_tile_sched.sv
// Bench for toy_conv_tile_sched: default geometry (dut 0) and COUT=8 (dut 1).
// Latency: cycle-exact expectations from a nested-loop layer model.
// Backpressure: wb_ready driven fixed, with a targeted stall, or randomly.
module tb_toy_conv_tile_sched;
  localparam int M    = 25;
  localparam int K    = 9;
  localparam int ARR  = 4;
  localparam int SKEW = 2 * ARR - 1;
  localparam int MT   = (M + ARR - 1) / ARR;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       acc_clr;
    logic       mac_en;
    logic       a_rd_en;
    logic [7:0] a_addr;
    logic       w_rd_en;
    logic [7:0] w_addr;
    logic       wb_valid;
    logic [1:0] wb_row;
    logic [4:0] wb_m;
    logic       wb_ct;
  } obs_t;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       start[2], abort[2], wb_ready[2];
  logic       busy[2], done[2], acc_clr[2], mac_en[2], a_rd_en[2], w_rd_en[2], wb_valid[2];
  logic [7:0] a_addr[2], w_addr[2];
  logic [1:0] wb_row[2];
  logic [4:0] wb_m[2];
  logic [0:0] wb_ct[2];

  int checks   = 0;
  int failures = 0;
  int cyc_ctr  = 0;
  int t0[2], t_done[2], done_cnt[2], hs[2];

  always #5 clk = ~clk;

  toy_conv_tile_sched #(.M(M), .K(K), .COUT(4), .ARR(ARR), .ADDR_W(8)) u_dut0 (
    .clk(clk), .n_rst(n_rst), .start(start[0]), .abort(abort[0]), .busy(busy[0]), .done(done[0]),
    .acc_clr(acc_clr[0]), .mac_en(mac_en[0]), .a_rd_en(a_rd_en[0]), .a_addr(a_addr[0]),
    .w_rd_en(w_rd_en[0]), .w_addr(w_addr[0]), .wb_valid(wb_valid[0]), .wb_ready(wb_ready[0]),
    .wb_row(wb_row[0]), .wb_m(wb_m[0]), .wb_ct(wb_ct[0])
  );

  toy_conv_tile_sched #(.M(M), .K(K), .COUT(8), .ARR(ARR), .ADDR_W(8)) u_dut1 (
    .clk(clk), .n_rst(n_rst), .start(start[1]), .abort(abort[1]), .busy(busy[1]), .done(done[1]),
    .acc_clr(acc_clr[1]), .mac_en(mac_en[1]), .a_rd_en(a_rd_en[1]), .a_addr(a_addr[1]),
    .w_rd_en(w_rd_en[1]), .w_addr(w_addr[1]), .wb_valid(wb_valid[1]), .wb_ready(wb_ready[1]),
    .wb_row(wb_row[1]), .wb_m(wb_m[1]), .wb_ct(wb_ct[1])
  );

  // Event monitor: done timing, done pulses and accepted writebacks.
  always @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (done[s] === 1'b1) begin
        t_done[s]   = cyc_ctr;
        done_cnt[s] = done_cnt[s] + 1;
      end
      if (wb_valid[s] === 1'b1 && wb_ready[s] === 1'b1) hs[s] = hs[s] + 1;
    end
    cyc_ctr = cyc_ctr + 1;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic obs_t obs(input int s);
    obs_t o;
    o.busy = busy[s];       o.done = done[s];     o.acc_clr = acc_clr[s];
    o.mac_en = mac_en[s];   o.a_rd_en = a_rd_en[s]; o.a_addr = a_addr[s];
    o.w_rd_en = w_rd_en[s]; o.w_addr = w_addr[s]; o.wb_valid = wb_valid[s];
    o.wb_row = wb_row[s];   o.wb_m = wb_m[s];     o.wb_ct = wb_ct[s][0];
    return o;
  endfunction

  function automatic obs_t e_busy();
    obs_t o = '0;
    o.busy = 1'b1;
    return o;
  endfunction

  task automatic step(input int s, input string tag, input obs_t e);
    @(negedge clk);
    check_val(tag, 64'(obs(s)), 64'(e));
  endtask

  // Layer model: loops over tiles and phases; checks every cycle.
  // cut: 0 none, 1 abort in FLUSH of mt=2, 2 reset in DRAIN of mt=1 row 1.
  // mode: 0 ready high, 1 random ready, 2 three stall cycles on global row 5.
  task automatic run_layer(input int s, input int ct_n, input int mode, input int cut,
                           input bit poke, input int exp_done, input int exp_hs, input int exp_dones);
    obs_t e;
    int   rows, stalls, hs0, dn0;
    bit   rdy;
    hs0 = hs[s]; dn0 = done_cnt[s]; t_done[s] = -1;
    start[s] = 1'b1; abort[s] = 1'b0; wb_ready[s] = 1'b1; t0[s] = cyc_ctr;
    for (int mt = 0; mt < MT; mt++) begin
      for (int ct = 0; ct < ct_n; ct++) begin
        e = e_busy(); e.acc_clr = 1'b1;
        step(s, "clr", e);
        start[s] = 1'b0;
        for (int k = 0; k < K; k++) begin
          e = e_busy(); e.mac_en = 1'b1; e.a_rd_en = 1'b1; e.w_rd_en = 1'b1;
          e.a_addr = 8'(mt * K + k); e.w_addr = 8'(ct * K + k);
          step(s, "feed", e);
          start[s] = (poke && mt == 0 && ct == 0 && k == 3);
        end
        for (int f = 0; f < SKEW; f++) begin
          e = e_busy(); e.mac_en = 1'b1;
          step(s, "flush", e);
          if (cut == 1 && mt == 2 && f == 2) begin
            abort[s] = 1'b1;
            step(s, "abort_idle", '0);
            abort[s] = 1'b0;
            repeat (3) step(s, "abort_stay", '0);
            check_val("abort_no_done", 64'(done_cnt[s] - dn0), 64'(exp_dones));
            check_val("abort_rows", 64'(hs[s] - hs0), 64'(exp_hs));
            return;
          end
        end
        rows = (M - mt * ARR < ARR) ? (M - mt * ARR) : ARR;
        for (int r = 0; r < rows; r++) begin
          stalls = 0;
          forever begin
            e = e_busy(); e.wb_valid = 1'b1; e.wb_row = 2'(r);
            e.wb_m = 5'(mt * ARR + r); e.wb_ct = 1'(ct);
            step(s, "drain", e);
            if (cut == 2 && mt == 1 && r == 1) begin
              #2 n_rst = 1'b0;
              #1 check_val("rst_async", 64'(obs(s)), 64'd0);
              @(negedge clk);
              n_rst = 1'b1; wb_ready[s] = 1'b1;
              repeat (3) step(s, "rst_idle", '0);
              check_val("rst_no_done", 64'(done_cnt[s] - dn0), 64'(exp_dones));
              check_val("rst_rows", 64'(hs[s] - hs0), 64'(exp_hs));
              return;
            end
            case (mode)
              1:       rdy = ($urandom_range(0, 3) != 0);
              2:       rdy = !((mt * ARR + r == 5) && stalls < 3);
              default: rdy = 1'b1;
            endcase
            if (!rdy) stalls++;
            wb_ready[s] = rdy;
            if (rdy) break;
          end
        end
        step(s, "next", e_busy());
      end
    end
    e = e_busy(); e.done = 1'b1;
    step(s, "done", e);
    step(s, "idle_after", '0);
    if (exp_done >= 0) check_val("done_cycle", 64'(t_done[s] - t0[s]), 64'(exp_done));
    check_val("wb_count", 64'(hs[s] - hs0), 64'(exp_hs));
    check_val("done_pulses", 64'(done_cnt[s] - dn0), 64'(exp_dones));
  endtask

  initial begin
    n_rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      start[s] = 1'b0; abort[s] = 1'b0; wb_ready[s] = 1'b1;
      t0[s] = 0; t_done[s] = -1; done_cnt[s] = 0; hs[s] = 0;
    end
    repeat (2) @(negedge clk);
    check_val("reset_dut0", 64'(obs(0)), 64'd0);
    check_val("reset_dut1", 64'(obs(1)), 64'd0);
    n_rst = 1'b1;
    step(0, "idle0", '0);
    // start and abort together in IDLE: abort wins
    start[0] = 1'b1; abort[0] = 1'b1;
    step(0, "start_abort_idle", '0);
    start[0] = 1'b0; abort[0] = 1'b0;
    step(0, "idle1", '0);

    run_layer(0, 1, 0, 0, 1'b0, 152, 25, 1);   // baseline
    run_layer(0, 1, 2, 0, 1'b0, 155, 25, 1);   // 3-cycle stall on row 5
    run_layer(1, 2, 0, 0, 1'b0, 303, 50, 1);   // COUT=8, two column tiles
    run_layer(0, 1, 0, 1, 1'b0, -1, 8, 0);     // abort in FLUSH of mt=2
    run_layer(0, 1, 0, 0, 1'b0, 152, 25, 1);   // restart after abort
    run_layer(0, 1, 0, 0, 1'b1, 152, 25, 1);   // start poked during FEED
    run_layer(0, 1, 0, 2, 1'b0, -1, 5, 0);     // reset mid-DRAIN
    run_layer(0, 1, 0, 0, 1'b0, 152, 25, 1);   // start after reset
    for (int i = 0; i < 3; i++) run_layer(0, 1, 1, 0, 1'b0, -1, 25, 1);
    run_layer(1, 2, 1, 0, 1'b0, -1, 50, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
